// File: rtl/mem_pkg.sv
// Shared constants and types for the data RAM and ROM access paths.
// Covers the size encoding, lane geometry and the responder state.
package mem_pkg;
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  typedef enum logic {IDLE, RESP} state_e;

  // Any encoding with bit1 set is a word access.
  function automatic size_e size_decode(input logic [1:0] hb);
    if (hb[1])             return SZ_WORD;
    else if (hb == HB_HALF) return SZ_HALF;
    else                    return SZ_BYTE;
  endfunction
endpackage

// File: rtl/data_ram_if.sv
// Request/acknowledge bus between the load/store unit and the data RAM.
interface data_ram_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  hb_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;

  modport master (output req_i, we_i, hb_i, addr_i, wdata_i,
                  input  rdata_o, ack_o, err_o);
  modport slave  (input  req_i, we_i, hb_i, addr_i, wdata_i,
                  output rdata_o, ack_o, err_o);
endinterface

// File: rtl/data_ram_lane_merge.sv
// Combinational byte-lane store merge, load extract and alignment check.
// Shared with the ROM extract path, which simply ignores the merged word.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  hb,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] rdata,
  output logic        misalign
);
  size_e                              size;
  logic [NUM_LANES-1:0]               be;
  logic [NUM_LANES-1:0][LANE_W-1:0]   old_b, wrep, mrg;
  logic [31:0]                        shifted;

  assign size    = size_decode(hb);
  assign old_b   = old_word;
  assign shifted = old_word >> {lane, 3'b000};

  always_comb begin
    be       = '0;
    wrep     = wdata;
    misalign = 1'b0;
    rdata    = old_word;
    case (size)
      SZ_BYTE: begin
        be[lane] = 1'b1;
        wrep     = {NUM_LANES{wdata[7:0]}};
        rdata    = {24'b0, shifted[7:0]};
      end
      SZ_HALF: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        rdata    = {16'b0, shifted[15:0]};
      end
      default: begin
        misalign = (lane != 2'd0);
        be       = '1;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign mrg[i] = be[i] ? wrep[i] : old_b[i];
  end

  assign merged = mrg;
endmodule

// File: rtl/data_ram.sv
// Single-port data memory responder: one access per two cycles, registered
// response with error flag for misaligned or out-of-range addresses.
module data_ram
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
)(
  input  logic        clk_i,
  input  logic        rst_i,
  data_ram_if.slave   bus
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic        ack_q, err_q;
  logic [31:0] rdata_q;

  logic [31:0] off, old_word, merged, ld_data;
  logic [AW-1:0] idx;
  logic        oor, misalign, fault, accept;

  assign off      = bus.addr_i - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign oor      = (bus.addr_i < BASE_ADDR) || (off[31:2] >= DEPTH_W);
  assign old_word = oor ? 32'b0 : mem[idx];
  assign fault    = oor | misalign;
  assign accept   = (state_q == IDLE) && bus.req_i;

  lane_merge u_lane (
    .old_word (old_word),
    .wdata    (bus.wdata_i),
    .hb       (bus.hb_i),
    .lane     (bus.addr_i[1:0]),
    .merged   (merged),
    .rdata    (ld_data),
    .misalign (misalign)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_i) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept;
      err_q   <= accept & fault;
      rdata_q <= (accept && !fault && !bus.we_i) ? ld_data : 32'b0;
    end
  end

  // Array is deliberately not reset; a store commits at the accepting edge.
  always_ff @(posedge clk_i) begin
    if (accept && !rst_i && bus.we_i && !fault) mem[idx] <= merged;
  end

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: byte-addressed reference model plus
// per-cycle comparison and hand-computed literal expectations.
module tb_data_ram;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_ram_if bus();

  data_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: flat byte store keyed by byte offset, busy flag for the
  // two-cycle handshake.
  logic [7:0]  mb [int];
  logic        busy = 1'b0;
  logic        exp_ack = 1'b0, exp_err = 1'b0, exp_known = 1'b1;
  logic [31:0] exp_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; exp_ack <= 1'b0; exp_err <= 1'b0; exp_rd <= '0; exp_known <= 1'b1;
    end else if (!busy && bus.req_i) begin
      logic [31:0] off, val;
      int nb;
      logic bad_acc, known;
      off = bus.addr_i - BASE;
      nb  = bus.hb_i[1] ? 4 : (bus.hb_i[0] ? 2 : 1);
      bad_acc = (bus.addr_i < BASE) || (off >= 32'(4 * DEPTH)) ||
                (nb == 2 && bus.addr_i[0]) || (nb == 4 && bus.addr_i[1:0] != 2'd0);
      val = '0; known = 1'b1;
      if (!bad_acc) begin
        for (int k = 0; k < nb; k++) begin
          if (bus.we_i) mb[int'(off) + k] = bus.wdata_i[8*k +: 8];
          else if (mb.exists(int'(off) + k)) val[8*k +: 8] = mb[int'(off) + k];
          else known = 1'b0;
        end
      end
      busy <= 1'b1; exp_ack <= 1'b1; exp_err <= bad_acc;
      exp_rd <= (bad_acc || bus.we_i) ? 32'b0 : val;
      exp_known <= bad_acc || bus.we_i || known;
    end else begin
      busy <= 1'b0; exp_ack <= 1'b0; exp_err <= 1'b0; exp_rd <= '0; exp_known <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("model_ack", {31'b0, bus.ack_o}, {31'b0, exp_ack});
    chk("model_err", {31'b0, bus.err_o}, {31'b0, exp_err});
    if (exp_known) chk("model_rdata", bus.rdata_o, exp_rd);
  end

  task automatic acc(input string name, input logic we, input logic [1:0] hb,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic chk_rd, input logic [31:0] rd, input logic er);
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.hb_i = hb; bus.addr_i = addr; bus.wdata_i = wd;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    @(negedge clk);
    chk({name, "_ack"}, {31'b0, bus.ack_o}, 32'd1);
    chk({name, "_err"}, {31'b0, bus.err_o}, {31'b0, er});
    if (chk_rd) chk({name, "_rd"}, bus.rdata_o, rd);
  endtask

  initial begin
    int acks;
    logic [3:0] pat;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.hb_i = 2'b00; bus.addr_i = '0; bus.wdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'b0, bus.ack_o}, 32'd0);
    chk("rst_err", {31'b0, bus.err_o}, 32'd0);
    chk("rst_rd", bus.rdata_o, 32'd0);
    rst = 1'b0;

    acc("st_w",   1, 2'b10, 32'h1000, 32'hDEADBEEF, 1, 32'h0, 0);
    acc("ld_w",   0, 2'b10, 32'h1000, 32'h0, 1, 32'hDEADBEEF, 0);
    acc("st_b",   1, 2'b00, 32'h1002, 32'hFFFFFF55, 1, 32'h0, 0);
    acc("ld_w2",  0, 2'b10, 32'h1000, 32'h0, 1, 32'hDE55BEEF, 0);
    acc("ld_b0",  0, 2'b00, 32'h1000, 32'h0, 1, 32'h000000EF, 0);
    acc("ld_b1",  0, 2'b00, 32'h1001, 32'h0, 1, 32'h000000BE, 0);
    acc("ld_b2",  0, 2'b00, 32'h1002, 32'h0, 1, 32'h00000055, 0);
    acc("ld_b3",  0, 2'b00, 32'h1003, 32'h0, 1, 32'h000000DE, 0);
    acc("st_h",   1, 2'b01, 32'h1002, 32'h1234A5A5, 1, 32'h0, 0);
    acc("ld_h2",  0, 2'b01, 32'h1002, 32'h0, 1, 32'h0000A5A5, 0);
    acc("ld_h0",  0, 2'b01, 32'h1000, 32'h0, 1, 32'h0000BEEF, 0);
    acc("ld_w11", 0, 2'b11, 32'h1000, 32'h0, 1, 32'hA5A5BEEF, 0);

    acc("st_w4",  1, 2'b10, 32'h1004, 32'h12345678, 1, 32'h0, 0);
    acc("mis_h",  0, 2'b01, 32'h1001, 32'h0, 1, 32'h0, 1);
    acc("mis_w",  1, 2'b10, 32'h1006, 32'hFFFFFFFF, 1, 32'h0, 1);
    acc("mis_bh", 1, 2'b01, 32'h1005, 32'hFFFFFFFF, 1, 32'h0, 1);
    acc("ld_w4",  0, 2'b10, 32'h1004, 32'h0, 1, 32'h12345678, 0);

    acc("oor_lo", 0, 2'b10, 32'h0FFC, 32'h0, 1, 32'h0, 1);
    acc("oor_hi", 1, 2'b10, 32'h1400, 32'hCAFECAFE, 1, 32'h0, 1);
    acc("st_top", 1, 2'b00, 32'h13FF, 32'h000000C3, 1, 32'h0, 0);
    acc("ld_top", 0, 2'b00, 32'h13FF, 32'h0, 1, 32'h000000C3, 0);
    acc("in_top", 0, 2'b10, 32'h13FC, 32'h0, 0, 32'h0, 0);

    // Held request: accepted on alternate edges only.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.hb_i = 2'b10; bus.addr_i = 32'h1000;
    acks = 0; pat = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pat[3-c] = bus.ack_o;
      if (bus.ack_o) acks++;
    end
    bus.req_i = 1'b0;
    chk("held_acks", 32'(acks), 32'd2);
    chk("held_pat", {28'b0, pat}, 32'h0000000A);
    @(negedge clk);

    // Reset during RESP: ack drops at once, committed store survives.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.hb_i = 2'b10; bus.addr_i = 32'h1008; bus.wdata_i = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    #1 chk("resp_ack_pre", {31'b0, bus.ack_o}, 32'd1);
    rst = 1'b1;
    #1 chk("rst_mid_ack", {31'b0, bus.ack_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acc("ld_after_rst", 0, 2'b10, 32'h1008, 32'h0, 1, 32'hCAFEF00D, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
